pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the multi-cycle LEGv8 core. Successor to the fixed 32-bit, fixed 5-cycle PC block.
- Holds the architectural PC and counts per-instruction stages with an internal counter. At the last stage it commits the next PC: sequential, conditional, unconditional or register-indirect.
- Adds stall, alignment fault detection and a one-cycle commit strobe for fetch and regfile sequencing. Sits between the control unit/ALU flags and instruction memory.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_target_mux.sv | 52 +++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// It holds the FSM state encoding, the target-select encoding and a constant clog2.
package pc_pkg;

    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_FAULT = 1'b1
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_REL = 2'd1,
        SEL_REG = 2'd2
    } pc_sel_t;

    // This function is used in constant expressions to size the stage counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC selection: register-indirect, PC-relative or sequential.
// It also flags a target that is not aligned to an instruction boundary.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int OFFSET_SHIFT = 2,
    parameter int INSTR_BYTES  = 4
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_cond_br,
    input  logic              i_uncond_br,
    input  logic              i_zero,
    input  logic              i_reg_br,
    input  logic [ADDR_W-1:0] i_br_reg,
    input  logic [ADDR_W-1:0] i_offset,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_misaligned
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] SEQ_INC    = ADDR_W'(INSTR_BYTES);

    logic signed [ADDR_W-1:0] w_off_s;
    logic        [ADDR_W-1:0] w_rel;
    logic        [ADDR_W-1:0] w_seq;
    pc_sel_t                  w_sel;

    // Bits shifted out of the top are dropped, and the sum wraps modulo 2^ADDR_W.
    assign w_off_s = $signed(i_offset) <<< OFFSET_SHIFT;
    assign w_rel   = i_pc + $unsigned(w_off_s);
    assign w_seq   = i_pc + SEQ_INC;

    always_comb begin
        w_sel = SEL_SEQ;
        if (i_reg_br)
            w_sel = SEL_REG;
        else if (i_uncond_br || (i_cond_br && i_zero))
            w_sel = SEL_REL;
    end

    always_comb begin
        case (w_sel)
            SEL_REG: o_target = i_br_reg;
            SEL_REL: o_target = w_rel;
            default: o_target = w_seq;
        endcase
    end

    assign o_misaligned = |(o_target & ALIGN_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle program counter. It counts STAGES cycles per instruction and commits the next PC on the last one.
// A misaligned target freezes the unit in FAULT until reset.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                STAGES       = 5,
    parameter int                OFFSET_SHIFT = 2,
    parameter int                INSTR_BYTES  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       stall,
    input  logic                       branchFlag,
    input  logic                       unconditionalBranchFlag,
    input  logic                       zeroFlag,
    input  logic                       registerBranchFlag,
    input  logic [ADDR_W-1:0]          branchRegister,
    input  logic [ADDR_W-1:0]          pcOffsetFilled,
    output logic [ADDR_W-1:0]          PC,
    output logic [clog2(STAGES)-1:0]   stage,
    output logic                       pcCommit,
    output logic                       alignFault
);

    localparam int                   STAGE_W    = clog2(STAGES);
    localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(STAGES - 1);

    pc_state_t           r_state;
    pc_state_t           w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [STAGE_W-1:0]  r_stage;
    logic [STAGE_W-1:0]  w_stage_nxt;
    logic                r_commit;
    logic                w_commit_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic [ADDR_W-1:0]   w_target;
    logic                w_misaligned;

    pc_target_mux #(
        .ADDR_W       (ADDR_W),
        .OFFSET_SHIFT (OFFSET_SHIFT),
        .INSTR_BYTES  (INSTR_BYTES)
    ) u_target_mux (
        .i_pc         (r_pc),
        .i_cond_br    (branchFlag),
        .i_uncond_br  (unconditionalBranchFlag),
        .i_zero       (zeroFlag),
        .i_reg_br     (registerBranchFlag),
        .i_br_reg     (branchRegister),
        .i_offset     (pcOffsetFilled),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state  <= PC_RUN;
            r_pc     <= RESET_VECTOR;
            r_stage  <= '0;
            r_commit <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_stage  <= w_stage_nxt;
            r_commit <= w_commit_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // A faulting commit keeps the stage at its last value, so the whole unit stays frozen where it stopped.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_stage_nxt  = r_stage;
        w_commit_nxt = 1'b0;
        w_fault_nxt  = r_fault;
        case (r_state)
            PC_RUN: begin
                if (!stall) begin
                    if (r_stage == LAST_STAGE) begin
                        if (w_misaligned) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = PC_FAULT;
                        end else begin
                            w_pc_nxt     = w_target;
                            w_stage_nxt  = '0;
                            w_commit_nxt = 1'b1;
                        end
                    end else begin
                        w_stage_nxt = r_stage + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = PC_FAULT;
            end
        endcase
    end

    assign PC         = r_pc;
    assign stage      = r_stage;
    assign pcCommit   = r_commit;
    assign alignFault = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Expected commit targets are queued when stimulus is set up,
// and they are checked against PC on each pcCommit pulse.
module tb_pc_sequencer;

    localparam int STG = 5;

    logic        clock = 1'b0;
    logic        resetN;
    logic        stall;
    logic        branchFlag;
    logic        unconditionalBranchFlag;
    logic        zeroFlag;
    logic        registerBranchFlag;
    logic [31:0] branchRegister;
    logic [31:0] pcOffsetFilled;
    logic [31:0] PC;
    logic [2:0]  stage;
    logic        pcCommit;
    logic        alignFault;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_commit = -1;
    int          prev_commit = -1;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    always #5 clock = ~clock;

    pc_sequencer #(
        .ADDR_W       (32),
        .STAGES       (STG),
        .OFFSET_SHIFT (2),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clock                   (clock),
        .resetN                  (resetN),
        .stall                   (stall),
        .branchFlag              (branchFlag),
        .unconditionalBranchFlag (unconditionalBranchFlag),
        .zeroFlag                (zeroFlag),
        .registerBranchFlag      (registerBranchFlag),
        .branchRegister          (branchRegister),
        .pcOffsetFilled          (pcOffsetFilled),
        .PC                      (PC),
        .stage                   (stage),
        .pcCommit                (pcCommit),
        .alignFault              (alignFault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and checks run at negedge+1, well away from the active edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            #1;
        end
    endtask

    task automatic clear_flags();
        branchFlag              = 1'b0;
        unconditionalBranchFlag = 1'b0;
        zeroFlag                = 1'b0;
        registerBranchFlag      = 1'b0;
        branchRegister          = 32'h0;
        pcOffsetFilled          = 32'h0;
    endtask

    task automatic instr(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        step(STG);
        chk(tag, PC, exp);
        chk({tag, "_commit"}, pcCommit, 1'b1);
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard: every commit pulse must match the oldest queued target.
    always @(negedge clock) begin
        if (pcCommit === 1'b1) begin
            prev_commit = last_commit;
            last_commit = cyc;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                chk("sb_pc", PC, sb_exp);
            end
        end
    end

    initial begin
        resetN = 1'b0;
        stall  = 1'b1;
        clear_flags();
        step(2);
        chk("rst_pc", PC, 32'h0);
        chk("rst_stage", stage, 3'd0);
        chk("rst_commit", pcCommit, 1'b0);
        chk("rst_fault", alignFault, 1'b0);

        // Sequential run
        stall  = 1'b0;
        resetN = 1'b1;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 1; i < STG; i++) begin
            step();
            chk("seq_pc_hold", PC, 32'h0);
            chk("seq_stage", stage, 64'(i));
        end
        step();
        chk("seq_pc_4", PC, 32'h4);
        chk("seq_stage_wrap", stage, 3'd0);
        chk("seq_commit", pcCommit, 1'b1);
        step();
        chk("seq_commit_pulse", pcCommit, 1'b0);
        step(STG - 1);
        chk("seq_pc_8", PC, 32'h8);

        // Conditional branches, taken and not taken
        branchFlag = 1'b1; zeroFlag = 1'b1; pcOffsetFilled = 32'd3;
        instr("cond_taken", 32'h14);
        clear_flags();
        registerBranchFlag = 1'b1; branchRegister = 32'h8;
        instr("reg_to_8", 32'h8);
        clear_flags();
        branchFlag = 1'b1; zeroFlag = 1'b0; pcOffsetFilled = 32'd3;
        instr("cond_not_taken", 32'hC);

        // Unconditional backward branch, then priority
        clear_flags();
        registerBranchFlag = 1'b1; branchRegister = 32'h10;
        instr("reg_to_10", 32'h10);
        clear_flags();
        unconditionalBranchFlag = 1'b1; pcOffsetFilled = 32'hFFFF_FFFE;
        instr("uncond_back", 32'h8);
        registerBranchFlag = 1'b1; branchRegister = 32'h40;
        branchFlag = 1'b1; zeroFlag = 1'b1;
        instr("prio_reg", 32'h40);
        clear_flags();

        // Stall mid-instruction
        exp_q.push_back(32'h44);
        step(2);
        chk("stall_stage_pre", stage, 3'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_stage", stage, 3'd2);
            chk("stall_pc", PC, 32'h40);
            chk("stall_commit", pcCommit, 1'b0);
        end
        stall = 1'b0;
        step(3);
        chk("stall_pc_after", PC, 32'h44);
        chk("stall_commit_after", pcCommit, 1'b1);
        chk("stall_gap", 64'(last_commit - prev_commit), 64'd8);

        // Stall at the commit stage: flags seen only on the releasing edge count
        exp_q.push_back(32'h48);
        step(STG - 1);
        chk("cstall_stage", stage, 3'd4);
        stall = 1'b1; registerBranchFlag = 1'b1; branchRegister = 32'h80;
        step(2);
        chk("cstall_stage_hold", stage, 3'd4);
        chk("cstall_pc_hold", PC, 32'h44);
        clear_flags();
        stall = 1'b0;
        step();
        chk("cstall_pc", PC, 32'h48);

        // Misaligned target
        registerBranchFlag = 1'b1; branchRegister = 32'h102;
        step(STG);
        chk("fault_set", alignFault, 1'b1);
        chk("fault_pc", PC, 32'h48);
        chk("fault_commit", pcCommit, 1'b0);
        for (int i = 0; i < 20; i++) begin
            stall                   = 1'($urandom_range(0, 1));
            registerBranchFlag      = 1'($urandom_range(0, 1));
            unconditionalBranchFlag = 1'($urandom_range(0, 1));
            branchFlag              = 1'($urandom_range(0, 1));
            zeroFlag                = 1'($urandom_range(0, 1));
            branchRegister          = $urandom & 32'hFFFF_FFFC;
            pcOffsetFilled          = $urandom;
            step();
            chk("frozen_pc", PC, 32'h48);
            chk("frozen_fault", alignFault, 1'b1);
            chk("frozen_commit", pcCommit, 1'b0);
        end
        clear_flags();
        stall  = 1'b0;
        resetN = 1'b0;
        step();
        chk("fault_rst_pc", PC, 32'h0);
        chk("fault_rst_stage", stage, 3'd0);
        chk("fault_rst_fault", alignFault, 1'b0);
        resetN = 1'b1;

        // Reset with a commit pending
        registerBranchFlag = 1'b1; branchRegister = 32'h200;
        step(STG - 1);
        chk("mid_stage", stage, 3'd4);
        resetN = 1'b0;
        step();
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_stage", stage, 3'd0);
        chk("mid_rst_commit", pcCommit, 1'b0);
        resetN = 1'b1;
        clear_flags();

        // Wrap at the top of the address space
        registerBranchFlag = 1'b1; branchRegister = 32'hFFFF_FFFC;
        instr("reg_to_top", 32'hFFFF_FFFC);
        clear_flags();
        instr("wrap", 32'h0);
        chk("wrap_fault", alignFault, 1'b0);

        step(2);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
